// File: rtl/tt_um_uwasic_onboarding_jeremy_zheng_if.sv
// tt_um_uwasic_onboarding_jeremy_zheng_if: Tiny Tapeout pin bundle between harness and user design
interface tt_um_uwasic_onboarding_jeremy_zheng_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_uwasic_onboarding_jeremy_zheng.sv
// tt_um_uwasic_onboarding_jeremy_zheng: SPI write-only register file driving 16 static/PWM output channels
module tt_um_uwasic_onboarding_jeremy_zheng #(
  parameter int PWM_PERIOD = 3333,
  parameter int MAX_ADDR   = 4
) (
  input logic clk,
  input logic rst_n,
  tt_um_uwasic_onboarding_jeremy_zheng_if.slave io
);
  localparam int CW = $clog2(PWM_PERIOD);
  logic [2:0] sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
  logic [15:0] sh_q, sh_d, en_out_q, en_out_d, en_pwm_q, en_pwm_d, out_q, out_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] duty_q, duty_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [19:0] prod;
  logic [6:0] addr;
  logic sclk_rise, ncs_fall, ncs_rise, commit, pwm;
  logic unused;
  assign unused = &{1'b0, io.ena, io.uio_in, io.ui_in[7:3]};
  assign io.uo_out = out_q[7:0];
  assign io.uio_out = out_q[15:8];
  assign io.uio_oe = 8'hFF;
  always_comb begin
    // bit [1] is the synchronized sample, bit [2] the previous one for edge detection
    sclk_d = {sclk_q[1:0], io.ui_in[0]};
    copi_d = {copi_q[1:0], io.ui_in[1]};
    ncs_d = {ncs_q[1:0], io.ui_in[2]};
    sclk_rise = sclk_q[1] & ~sclk_q[2];
    ncs_fall = ~ncs_q[1] & ncs_q[2];
    ncs_rise = ncs_q[1] & ~ncs_q[2];
    sh_d = ncs_fall ? 16'h0 : (~ncs_q[1] & sclk_rise) ? {sh_q[14:0], copi_q[1]} : sh_q;
    cnt_d = ncs_fall ? 5'd0 : (~ncs_q[1] & sclk_rise & (cnt_q != 5'd17)) ? cnt_q + 5'd1 : cnt_q;
    addr = sh_q[14:8];
    commit = ncs_rise & (cnt_q == 5'd16) & sh_q[15] & (addr <= 7'(MAX_ADDR));
    en_out_d[7:0] = (commit && addr == 7'd0) ? sh_q[7:0] : en_out_q[7:0];
    en_out_d[15:8] = (commit && addr == 7'd1) ? sh_q[7:0] : en_out_q[15:8];
    en_pwm_d[7:0] = (commit && addr == 7'd2) ? sh_q[7:0] : en_pwm_q[7:0];
    en_pwm_d[15:8] = (commit && addr == 7'd3) ? sh_q[7:0] : en_pwm_q[15:8];
    duty_d = (commit && addr == 7'd4) ? sh_q[7:0] : duty_q;
    pcnt_d = (pcnt_q == CW'(PWM_PERIOD - 1)) ? '0 : pcnt_q + 1'b1;
    prod = 20'(duty_q) * 20'(PWM_PERIOD);
    pwm = (duty_q == 8'hFF) || (20'(pcnt_q) < (prod >> 8));
    out_d = en_out_q & (~en_pwm_q | {16{pwm}});
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sclk_q <= 3'b000;
      copi_q <= 3'b000;
      ncs_q <= 3'b111;
      sh_q <= '0;
      cnt_q <= '0;
      en_out_q <= '0;
      en_pwm_q <= '0;
      duty_q <= '0;
      pcnt_q <= '0;
      out_q <= '0;
    end else begin
      sclk_q <= sclk_d;
      copi_q <= copi_d;
      ncs_q <= ncs_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      duty_q <= duty_d;
      pcnt_q <= pcnt_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_tt_um_uwasic_onboarding_jeremy_zheng.sv
// tb_tt_um_uwasic_onboarding_jeremy_zheng: directed + random SPI frames checked against a register-map model
module tb_tt_um_uwasic_onboarding_jeremy_zheng;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] regs [5];
  always #50 clk = ~clk;
  tt_um_uwasic_onboarding_jeremy_zheng_if io ();
  tt_um_uwasic_onboarding_jeremy_zheng dut (.clk(clk), .rst_n(rst_n), .io(io));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic clear_model();
    foreach (regs[i]) regs[i] = 8'h00;
  endtask

  // Bits driven by an unpredictable PWM phase are masked out of the comparison
  task automatic model_out(output logic [15:0] exp, output logic [15:0] known);
    logic [15:0] eo, ep;
    logic fixed;
    eo = {regs[1], regs[0]};
    ep = {regs[3], regs[2]};
    fixed = (regs[4] == 8'h00) || (regs[4] == 8'hFF);
    for (int i = 0; i < 16; i++) begin
      exp[i] = !eo[i] ? 1'b0 : !ep[i] ? 1'b1 : (regs[4] == 8'hFF);
      known[i] = !(eo[i] && ep[i]) || fixed;
    end
  endtask

  task automatic check_out(input string tag);
    logic [15:0] exp, known;
    model_out(exp, known);
    check(tag, 32'({io.uio_out, io.uo_out} & known), 32'(exp & known));
  endtask

  task automatic spi(input logic [15:0] w, input int nbits);
    io.ui_in[2] = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      io.ui_in[1] = (i < 16) ? w[15-i] : 1'b0;
      tick(4);
      io.ui_in[0] = 1'b1;
      tick(4);
      io.ui_in[0] = 1'b0;
    end
    tick(4);
    io.ui_in[2] = 1'b1;
    tick(8);
    if (nbits == 16 && w[15] && w[14:8] <= 7'd4) regs[int'(w[14:8])] = w[7:0];
  endtask

  task automatic measure(output int hi, output int per);
    int n;
    n = 0;
    while (io.uo_out[0] !== 1'b0 && n < 5000) begin tick(1); n++; end
    while (io.uo_out[0] !== 1'b1 && n < 10000) begin tick(1); n++; end
    hi = 0;
    while (io.uo_out[0] === 1'b1 && hi < 5000) begin tick(1); hi++; end
    per = hi;
    while (io.uo_out[0] === 1'b0 && per < 10000) begin tick(1); per++; end
  endtask

  initial begin
    int hi, per, cnt;
    logic [15:0] w;
    int nb;
    io.ena = 1'b1;
    io.ui_in = 8'b0000_0100;
    io.uio_in = 8'h00;
    clear_model();
    tick(5);
    check("reset_uo", 32'(io.uo_out), 32'h00);
    check("reset_uio", 32'(io.uio_out), 32'h00);
    check("reset_oe", 32'(io.uio_oe), 32'hFF);
    rst_n = 1'b0;
    tick(2);
    spi(16'h80F0, 16);
    spi(16'h81CC, 16);
    check("static_uo", 32'(io.uo_out), 32'hF0);
    check("static_uio", 32'(io.uio_out), 32'hCC);
    check_out("static_model");
    spi(16'h85AA, 16);
    check("bad_addr", 32'(io.uo_out), 32'hF0);
    spi(16'h00FF, 16);
    check("read_frame", 32'(io.uo_out), 32'hF0);
    spi(16'h800F, 15);
    check("short_frame", 32'(io.uo_out), 32'hF0);
    spi(16'h800F, 17);
    check("long_frame", 32'(io.uo_out), 32'hF0);
    check_out("invalid_model");
    spi(16'h8001, 16);
    spi(16'h8201, 16);
    spi(16'h8480, 16);
    measure(hi, per);
    check_range("pwm50_high", hi, 1665, 1667);
    check_range("pwm50_period", per, 3332, 3334);
    spi(16'h8400, 16);
    cnt = 0;
    for (int i = 0; i < 6666; i++) begin tick(1); cnt += int'(io.uo_out[0]); end
    check("duty00_highs", 32'(cnt), 32'd0);
    spi(16'h84FF, 16);
    cnt = 0;
    for (int i = 0; i < 6666; i++) begin tick(1); cnt += int'(!io.uo_out[0]); end
    check("dutyFF_lows", 32'(cnt), 32'd0);
    for (int k = 0; k < 25; k++) begin
      w[15] = ($urandom_range(0, 3) != 0);
      w[14:8] = 7'($urandom_range(0, 7));
      w[7:0] = 8'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? 15 + 2 * int'($urandom_range(0, 1)) : 16;
      spi(w, nb);
      check_out($sformatf("rand%0d_w%04h_n%0d", k, w, nb));
    end
    io.ui_in[2] = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      io.ui_in[1] = 1'b1;
      tick(4);
      io.ui_in[0] = 1'b1;
      tick(4);
      io.ui_in[0] = 1'b0;
    end
    rst_n = 1'b1;
    io.ui_in[2] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    clear_model();
    tick(1);
    check("midrst_uo", 32'(io.uo_out), 32'h00);
    check("midrst_uio", 32'(io.uio_out), 32'h00);
    spi(16'h8055, 16);
    check("after_rst_uo", 32'(io.uo_out), 32'h55);
    check("after_rst_uio", 32'(io.uio_out), 32'h00);
    check_out("after_rst_model");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_uwasic_onboarding_jeremy_zheng.md
Name: tt_um_uwasic_onboarding_jeremy_zheng

Overview:
Tiny Tapeout user top combining an SPI-mode-0 write-only register interface with a 16-channel output driver. Each channel is forced low, driven high, or driven by one shared PWM signal (~3 kHz at a 10 MHz clock) whose duty cycle comes from an 8-bit register. Channels 7:0 drive uo_out and channels 15:8 drive uio_out.

Parameters:
PWM_PERIOD, 3333, PWM period in clk cycles (counter runs 0..PWM_PERIOD-1)
MAX_ADDR, 4, highest valid register address

Ports:
clk  input  1  system clock (10 MHz nominal)
rst_n  input  1  reset; synchronous, active-high (asserted when 1), sampled on rising clk
ena  input  1  design-selected flag; ignored
ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low chip select), [7:3] unused
uio_in  input  8  unused
uo_out  output  8  channel outputs 7:0
uio_out  output  8  channel outputs 15:8
uio_oe  output  8  constant 8'hFF (all bidirectionals are outputs)

Behaviour:
- All state on rising clk. Reset clears all registers, synchronizers (to SCLK=0, COPI=0, nCS=1), shift register, bit counter and PWM counter; uo_out=uio_out=0 from the first clock after reset.
- SCLK, COPI, nCS each pass through a 2-flop synchronizer. Edges are detected from the last two synchronized samples. Added latency is 2-3 clk. SCLK must be at most clk/4.
- Transaction framing:
  - nCS falling edge clears the bit counter and shift register.
  - While nCS is low, each synchronized SCLK rising edge shifts COPI in, MSB first, and increments the counter. The counter saturates at 17.
  - Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Commit on nCS rising edge, only when exactly 16 bits were received, R/W = 1 and address <= MAX_ADDR. The target register updates within one clk of the detected edge.
- Discarded frames, with no register change:
  - reads (R/W = 0); there is no CIPO/readback;
  - addresses 5..127;
  - frames of fewer or more than 16 bits.
- Register map, all 8-bit and reset to 0x00:
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty
- PWM:
  - Counter counts 0..PWM_PERIOD-1 and wraps to 0.
  - pwm = 1 when duty == 0xFF (constant high).
  - Otherwise pwm = (counter < (duty*PWM_PERIOD)>>8), using an unsigned product at least 20 bits wide.
  - duty 0 gives constant low. duty 0x80 gives 1666 high cycles out of 3333.
- Channel i output:
  - en_out[i] = 0 → 0;
  - en_out[i] = 1 and en_pwm[i] = 0 → 1;
  - en_out[i] = 1 and en_pwm[i] = 1 → pwm.
  - Outputs are registered, so they are glitch-free.
- A duty write takes effect immediately: the compare uses the new value on the next clk, and the counter is not reset.
- Reset asserted mid-transaction aborts the frame. The first nCS falling edge after reset starts a fresh frame.

Test Plan:
- Reset: hold rst_n=1 for 5 clk → uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
- Static outputs: write 0x80 0xF0 (en_out[7:0]=0xF0) and 0x81 0xCC → uo_out=0xF0, uio_out=0xCC.
- PWM 50%: write en_out[7:0]=0x01, en_pwm[7:0]=0x01, duty=0x80 → uo_out[0] period 3333±1 clk (~3 kHz), high time 1666±1 clk.
- PWM extremes: duty=0x00 → uo_out[0] constant 0 over 2 periods; duty=0xFF → constant 1 over 2 periods.
- Invalid frames: write to address 0x05, a read frame 0x00 0xFF, and a 15-bit write to addr 0 → uo_out unchanged.
- Reset mid-frame: assert rst_n after 8 bits, release, then send a full write 0x80 0x55 → uo_out=0x55 and all other registers 0.
